// File: rtl/fetch_unit.sv
// Instruction fetch: drives a synchronous INST_MEM, buffers responses in a 2-entry queue for decode.
// Latency: address issued in cycle c reaches the queue head in cycle c+2; one instruction per cycle sustained.
// Backpressure: id_ready low holds the head; a credit check stops issue before the queue could overflow.
module fetch_unit #(
    parameter logic [31:0] RESET_PC     = 32'd0,
    parameter logic [31:0] MAX_ADDR     = 32'd232,
    parameter int unsigned HALT_ON_ZERO = 1
) (
    input  logic        clk_50,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_inst,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        id_ready,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        halted,
    output logic [31:0] fetch_cnt
);

    logic [31:0]       pc_q, pc_d;
    logic              infl_q, infl_d;
    logic [31:0]       infl_pc_q, infl_pc_d;
    logic [1:0][31:0]  q_pc_q, q_pc_d;
    logic [1:0][31:0]  q_inst_q, q_inst_d;
    logic              head_q, head_d;
    logic              tail_q, tail_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              halted_q, halted_d;
    logic [31:0]       fetch_cnt_q, fetch_cnt_d;

    logic              pop;
    logic              push;
    logic              resp_zero;
    logic              pc_over;
    logic              issue;
    logic [2:0]        credit;

    assign if_valid  = (cnt_q != 2'd0);
    assign pop       = if_valid & id_ready;
    assign pc_over   = (pc_q > MAX_ADDR);
    assign credit    = {1'b0, cnt_q} + {2'b00, infl_q} - {2'b00, pop};
    // A zero word is the memory's default content: treat it as end of program.
    assign resp_zero = infl_q & (HALT_ON_ZERO != 0) & (imem_inst == 32'd0);
    assign push      = infl_q & ~resp_zero & ~br_taken;
    assign issue     = ~halted_q & ~pc_over & (credit <= 3'd1) & ~resp_zero;

    assign imem_addr = br_taken ? br_target : pc_q;
    assign if_pc     = if_valid ? q_pc_q[head_q]   : 32'd0;
    assign if_inst   = if_valid ? q_inst_q[head_q] : 32'd0;
    assign halted    = halted_q | pc_over;
    assign fetch_cnt = fetch_cnt_q;

    always_comb begin
        pc_d        = pc_q;
        infl_d      = 1'b0;
        infl_pc_d   = infl_pc_q;
        q_pc_d      = q_pc_q;
        q_inst_d    = q_inst_q;
        head_d      = head_q;
        tail_d      = tail_q;
        cnt_d       = cnt_q;
        halted_d    = halted_q;
        fetch_cnt_d = fetch_cnt_q + {31'd0, pop};

        if (br_taken) begin
            // Redirect drops queue and in-flight response, and fetches the target right away.
            cnt_d     = 2'd0;
            head_d    = 1'b0;
            tail_d    = 1'b0;
            halted_d  = 1'b0;
            infl_d    = 1'b1;
            infl_pc_d = br_target;
            pc_d      = br_target + 32'd4;
        end else begin
            if (push) begin
                q_pc_d[tail_q]   = infl_pc_q;
                q_inst_d[tail_q] = imem_inst;
                tail_d           = ~tail_q;
            end
            if (pop) begin
                head_d = ~head_q;
            end
            cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
            if (resp_zero) begin
                halted_d = 1'b1;
            end
            if (issue) begin
                infl_d    = 1'b1;
                infl_pc_d = pc_q;
                pc_d      = pc_q + 32'd4;
            end
        end
    end

    always_ff @(posedge clk_50 or negedge rst) begin
        if (!rst) begin
            pc_q        <= RESET_PC;
            infl_q      <= 1'b0;
            infl_pc_q   <= 32'd0;
            q_pc_q      <= '0;
            q_inst_q    <= '0;
            head_q      <= 1'b0;
            tail_q      <= 1'b0;
            cnt_q       <= 2'd0;
            halted_q    <= 1'b0;
            fetch_cnt_q <= 32'd0;
        end else begin
            pc_q        <= pc_d;
            infl_q      <= infl_d;
            infl_pc_q   <= infl_pc_d;
            q_pc_q      <= q_pc_d;
            q_inst_q    <= q_inst_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            cnt_q       <= cnt_d;
            halted_q    <= halted_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a synchronous instruction memory model.
module tb_fetch_unit;

    logic        clk_50 = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_inst = 32'd0;
    logic        br_taken;
    logic [31:0] br_target;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        halted;
    logic [31:0] fetch_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem [0:63];

    fetch_unit dut (
        .clk_50    (clk_50),
        .rst       (rst),
        .imem_addr (imem_addr),
        .imem_inst (imem_inst),
        .br_taken  (br_taken),
        .br_target (br_target),
        .id_ready  (id_ready),
        .if_valid  (if_valid),
        .if_pc     (if_pc),
        .if_inst   (if_inst),
        .halted    (halted),
        .fetch_cnt (fetch_cnt)
    );

    always #5 clk_50 = ~clk_50;

    always @(posedge clk_50)
        imem_inst <= (imem_addr < 32'd256) ? mem[imem_addr[7:2]] : 32'd0;

    function automatic logic [31:0] word_of(input int i);
        logic [7:0] idx;
        idx = 8'(i);
        if (i == 5) return 32'hfec10113;
        if (i > 58) return 32'd0;
        return {8'hA0, idx, 16'h0013};
    endfunction

    task automatic tick();
        @(posedge clk_50);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    initial begin
        rst       = 1'b0;
        id_ready  = 1'b0;
        br_taken  = 1'b0;
        br_target = 32'd0;
        for (int i = 0; i < 64; i++) mem[i] = word_of(i);

        repeat (3) tick();
        check_eq("rst_valid", {31'd0, if_valid}, 32'd0);
        check_eq("rst_pc", if_pc, 32'd0);
        check_eq("rst_inst", if_inst, 32'd0);
        check_eq("rst_halted", {31'd0, halted}, 32'd0);
        check_eq("rst_cnt", fetch_cnt, 32'd0);
        check_eq("rst_addr", imem_addr, 32'd0);

        // Sequential fetch from reset
        rst = 1'b1;
        id_ready = 1'b1;
        tick();
        check_eq("lat_valid0", {31'd0, if_valid}, 32'd0);
        tick();
        check_eq("lat_valid1", {31'd0, if_valid}, 32'd1);
        check_eq("first_pc", if_pc, 32'd0);
        check_eq("first_inst", if_inst, word_of(0));
        for (int k = 1; k <= 5; k++) begin
            tick();
            check_eq("seq_pc", if_pc, 32'(4 * k));
        end
        check_eq("pc20_inst", if_inst, 32'hfec10113);

        // Decode stall at PC 20
        id_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            tick();
            check_eq("stall_pc", if_pc, 32'd20);
            check_eq("stall_inst", if_inst, 32'hfec10113);
        end
        check_eq("stall_cnt_q", {30'd0, dut.cnt_q}, 32'd2);
        id_ready = 1'b1;
        for (int k = 6; k <= 25; k++) begin
            tick();
            check_eq("resume_pc", if_pc, 32'(4 * k));
        end
        check_eq("fcnt_at100", fetch_cnt, 32'd25);

        // Redirect to 68 with 100,104 queued
        id_ready = 1'b0;
        tick();
        check_eq("q2_head", if_pc, 32'd100);
        check_eq("q2_cnt_q", {30'd0, dut.cnt_q}, 32'd2);
        check_eq("q2_addr", imem_addr, 32'd108);
        br_taken  = 1'b1;
        br_target = 32'd68;
        #1;
        check_eq("br_addr", imem_addr, 32'd68);
        tick();
        br_taken = 1'b0;
        check_eq("br_flush_valid", {31'd0, if_valid}, 32'd0);
        check_eq("br_fcnt", fetch_cnt, 32'd25);
        tick();
        check_eq("br_valid", {31'd0, if_valid}, 32'd1);
        check_eq("br_pc68", if_pc, 32'd68);
        check_eq("br_inst68", if_inst, word_of(17));
        id_ready = 1'b1;
        tick();
        check_eq("br_pc72", if_pc, 32'd72);
        check_eq("br_fcnt72", fetch_cnt, 32'd26);

        // Redirect coinciding with a pop while the queue is full
        id_ready = 1'b0;
        tick();
        check_eq("full_pc", if_pc, 32'd72);
        check_eq("full_cnt_q", {30'd0, dut.cnt_q}, 32'd2);
        id_ready  = 1'b1;
        br_taken  = 1'b1;
        br_target = 32'd160;
        tick();
        br_taken = 1'b0;
        check_eq("brpop_fcnt", fetch_cnt, 32'd27);
        check_eq("brpop_valid", {31'd0, if_valid}, 32'd0);
        check_eq("brpop_pc", if_pc, 32'd0);
        check_eq("brpop_cnt_q", {30'd0, dut.cnt_q}, 32'd0);
        tick();
        check_eq("brpop_pc160", if_pc, 32'd160);
        tick();
        check_eq("brpop_pc164", if_pc, 32'd164);
        check_eq("brpop_fcnt164", fetch_cnt, 32'd28);

        // Asynchronous reset during a full stall
        id_ready = 1'b0;
        tick();
        tick();
        check_eq("pre_rst_cnt_q", {30'd0, dut.cnt_q}, 32'd2);
        #2;
        rst = 1'b0;
        #1;
        check_eq("arst_valid", {31'd0, if_valid}, 32'd0);
        check_eq("arst_pc", if_pc, 32'd0);
        check_eq("arst_inst", if_inst, 32'd0);
        check_eq("arst_halted", {31'd0, halted}, 32'd0);
        check_eq("arst_fcnt", fetch_cnt, 32'd0);
        check_eq("arst_addr", imem_addr, 32'd0);
        tick();
        tick();
        rst = 1'b1;
        id_ready = 1'b1;

        // Run through the end of the program
        tick();
        check_eq("rerun_valid0", {31'd0, if_valid}, 32'd0);
        tick();
        check_eq("rerun_pc0", if_pc, 32'd0);
        for (int k = 1; k <= 58; k++) begin
            tick();
            check_eq("run_pc", if_pc, 32'(4 * k));
        end
        check_eq("end_halted", {31'd0, halted}, 32'd1);
        tick();
        check_eq("end_valid", {31'd0, if_valid}, 32'd0);
        check_eq("end_fcnt", fetch_cnt, 32'd59);
        tick();
        tick();
        check_eq("end_valid_hold", {31'd0, if_valid}, 32'd0);
        check_eq("end_fcnt_hold", fetch_cnt, 32'd59);
        check_eq("end_halted_hold", {31'd0, halted}, 32'd1);
        br_taken  = 1'b1;
        br_target = 32'd0;
        #1;
        check_eq("restart_addr", imem_addr, 32'd0);
        tick();
        br_taken = 1'b0;
        check_eq("restart_halted", {31'd0, halted}, 32'd0);
        tick();
        check_eq("restart_pc0", if_pc, 32'd0);
        check_eq("restart_inst0", if_inst, word_of(0));
        tick();
        check_eq("restart_pc4", if_pc, 32'd4);
        check_eq("restart_fcnt", fetch_cnt, 32'd60);

        // Zero word inside the program halts fetch
        mem[50]   = 32'd0;
        br_taken  = 1'b1;
        br_target = 32'd192;
        tick();
        br_taken = 1'b0;
        check_eq("z_fcnt_br", fetch_cnt, 32'd61);
        tick();
        check_eq("z_pc192", if_pc, 32'd192);
        tick();
        check_eq("z_pc196", if_pc, 32'd196);
        check_eq("z_fcnt196", fetch_cnt, 32'd62);
        tick();
        check_eq("z_valid", {31'd0, if_valid}, 32'd0);
        check_eq("z_halted", {31'd0, halted}, 32'd1);
        check_eq("z_fcnt", fetch_cnt, 32'd63);
        tick();
        check_eq("z_valid_hold", {31'd0, if_valid}, 32'd0);
        check_eq("z_pc_held", imem_addr, 32'd204);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
